// File: rtl/ex_commit_ctrl.sv
// Exception / interrupt / ertn commit sequencer between WB and the CSR unit.
// A trigger in IDLE drives a one-cycle CSR pulse, a redirect handshake, then a drain.
module ex_commit_ctrl #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb_valid,
   input  logic             wb_ex,
   input  logic [5:0]       wb_ecode,
   input  logic [8:0]       wb_esubcode,
   input  logic             wb_ertn,
   input  logic [31:0]      wb_pc,
   input  logic             has_int,
   input  logic [31:0]      ex_entry,
   input  logic [31:0]      era_pc,
   output logic             wb_ready,
   output logic             wb_kill,
   output logic [48:0]      csr_in_bus,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ready,
   output logic [CNT_W-1:0] trap_cnt
);

   typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, DRAIN} state_t;

   localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

   state_t           state, state_n;
   logic             trigger;
   logic             ertn_q;
   logic [5:0]       ecode_q;
   logic [8:0]       esub_q;
   logic [31:0]      pc_q;
   logic [31:0]      rpc_q;
   logic [3:0]       drain_q;
   logic [CNT_W-1:0] cnt_q;
   logic             flush_q;

   assign trigger     = wb_valid && (has_int || wb_ex || wb_ertn);
   assign flush       = flush_q;
   assign redirect_pc = rpc_q;
   assign trap_cnt    = cnt_q;

   always_comb begin
      state_n        = state;
      wb_ready       = 1'b0;
      wb_kill        = 1'b0;
      redirect_valid = 1'b0;
      csr_in_bus     = '0;
      case (state)
         IDLE: begin
            wb_ready = 1'b1;
            wb_kill  = trigger;
            if (trigger) state_n = COMMIT;
         end
         COMMIT: begin
            csr_in_bus = {ertn_q, ~ertn_q, ecode_q, esub_q, pc_q};
            state_n    = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            if (redirect_ready) state_n = DRAIN;
         end
         DRAIN: begin
            if (drain_q == 4'd1) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         flush_q <= 1'b0;
         ertn_q  <= 1'b0;
         ecode_q <= '0;
         esub_q  <= '0;
         pc_q    <= '0;
         rpc_q   <= '0;
         drain_q <= '0;
         cnt_q   <= '0;
      end else begin
         state   <= state_n;
         flush_q <= (state_n != IDLE);
         case (state)
            IDLE: begin
               if (trigger) begin
                  // Interrupt outranks a same-cycle exception; ertn only when neither is present.
                  ertn_q  <= !has_int && !wb_ex;
                  ecode_q <= (!has_int && wb_ex) ? wb_ecode    : 6'h00;
                  esub_q  <= (!has_int && wb_ex) ? wb_esubcode : 9'h000;
                  pc_q    <= wb_pc;
               end
            end
            COMMIT: begin
               // The CSR unit only moves entry/ERA on the edge that ends this cycle.
               rpc_q <= ertn_q ? era_pc : ex_entry;
               if (!ertn_q && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
            end
            REDIRECT: begin
               if (redirect_ready) drain_q <= DRAIN_LD;
            end
            DRAIN: begin
               drain_q <= drain_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_commit_ctrl.sv
// Bench for ex_commit_ctrl: directed table, multi-cycle corner sequences, random vs timeline model.
module tb_ex_commit_ctrl;
   localparam int D = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid, wb_ex, wb_ertn, has_int, redirect_ready;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, ex_entry, era_pc;

   logic        wb_ready, wb_kill, flush, redirect_valid;
   logic [48:0] csr_in_bus;
   logic [31:0] redirect_pc;
   logic [15:0] trap_cnt;

   logic        wb_ready_s, wb_kill_s, flush_s, redirect_valid_s;
   logic [48:0] csr_in_bus_s;
   logic [31:0] redirect_pc_s;
   logic [1:0]  trap_cnt_s;

   always #5 clk = ~clk;

   ex_commit_ctrl #(.DRAIN_CYCLES(D), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
      .wb_esubcode(wb_esubcode), .wb_ertn(wb_ertn), .wb_pc(wb_pc), .has_int(has_int),
      .ex_entry(ex_entry), .era_pc(era_pc), .wb_ready(wb_ready), .wb_kill(wb_kill),
      .csr_in_bus(csr_in_bus), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .trap_cnt(trap_cnt));

   ex_commit_ctrl #(.DRAIN_CYCLES(D), .CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
      .wb_esubcode(wb_esubcode), .wb_ertn(wb_ertn), .wb_pc(wb_pc), .has_int(has_int),
      .ex_entry(ex_entry), .era_pc(era_pc), .wb_ready(wb_ready_s), .wb_kill(wb_kill_s),
      .csr_in_bus(csr_in_bus_s), .flush(flush_s), .redirect_valid(redirect_valid_s),
      .redirect_pc(redirect_pc_s), .redirect_ready(redirect_ready), .trap_cnt(trap_cnt_s));

   int errors = 0;
   int checks = 0;

   // Timeline model: phase is derived from the trigger cycle and the handshake cycle.
   typedef enum {M_IDLE, M_COMMIT, M_REDIR, M_DRAIN} mode_t;
   int          cyc = 0, t_trig = 0, t_hs = 0, m_cnt = 0;
   bit          m_busy = 0, m_hs = 0, m_ertn = 0;
   logic [5:0]  m_ec;
   logic [8:0]  m_es;
   logic [31:0] m_pc, m_rpc;

   function automatic mode_t mode_now();
      if (!m_busy) return M_IDLE;
      if (cyc == t_trig + 1) return M_COMMIT;
      if (!m_hs) return M_REDIR;
      return M_DRAIN;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic settle();
      mode_t       md;
      logic        trig;
      logic [48:0] ebus;
      #1;
      md   = mode_now();
      trig = wb_valid && (has_int || wb_ex || wb_ertn);
      ebus = (md == M_COMMIT) ? {m_ertn, !m_ertn, m_ec, m_es, m_pc} : 49'h0;
      chk("wb_ready", 64'(wb_ready), 64'(md == M_IDLE));
      chk("wb_kill", 64'(wb_kill), 64'((md == M_IDLE) && trig));
      chk("csr_in_bus", 64'(csr_in_bus), 64'(ebus));
      chk("flush", 64'(flush), 64'(md != M_IDLE));
      chk("redirect_valid", 64'(redirect_valid), 64'(md == M_REDIR));
      if (md == M_REDIR) chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
      chk("trap_cnt", 64'(trap_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
      chk("trap_cnt_sat", 64'(trap_cnt_s), 64'((m_cnt > 3) ? 3 : m_cnt));
      chk("small_bus", 64'(csr_in_bus_s), 64'(ebus));
   endtask

   task automatic advance();
      case (mode_now())
         M_IDLE: if (wb_valid && (has_int || wb_ex || wb_ertn)) begin
            m_busy = 1; m_hs = 0; t_trig = cyc;
            m_ertn = !has_int && !wb_ex;
            m_ec   = has_int ? 6'h00 : (wb_ex ? wb_ecode : 6'h00);
            m_es   = has_int ? 9'h000 : (wb_ex ? wb_esubcode : 9'h000);
            m_pc   = wb_pc;
         end
         M_COMMIT: begin
            m_rpc = m_ertn ? era_pc : ex_entry;
            if (!m_ertn) m_cnt++;
         end
         M_REDIR: if (redirect_ready) begin m_hs = 1; t_hs = cyc; end
         M_DRAIN: if (cyc == t_hs + D) m_busy = 0;
         default: ;
      endcase
      cyc++;
      @(negedge clk);
   endtask

   task automatic set_wb(input logic v, input logic hi, input logic ex, input logic er,
                         input logic [5:0] ec, input logic [8:0] es, input logic [31:0] pc);
      wb_valid = v; has_int = hi; wb_ex = ex; wb_ertn = er;
      wb_ecode = ec; wb_esubcode = es; wb_pc = pc;
   endtask

   typedef struct {
      logic hi, ex, er;
      logic [5:0]  ec;
      logic [8:0]  es;
      logic [31:0] pc, entry, era;
      logic [48:0] exp_bus;
      logic [31:0] exp_rpc;
      int          exp_cnt;
   } vec_t;
   vec_t tbl [3];

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b0, 6'h0B, 9'h000, 32'h1C000100, 32'h1C008000, 32'h0,
                 {1'b0, 1'b1, 6'h0B, 9'h000, 32'h1C000100}, 32'h1C008000, 1};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 6'h15, 9'h0AA, 32'h1C000200, 32'h1C008000, 32'h1C000104,
                 {1'b1, 1'b0, 6'h00, 9'h000, 32'h1C000200}, 32'h1C000104, 1};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 6'h0C, 9'h003, 32'h1C000300, 32'h1C00A000, 32'h0,
                 {1'b0, 1'b1, 6'h00, 9'h000, 32'h1C000300}, 32'h1C00A000, 2};

      reset = 1'b1; redirect_ready = 1'b0; ex_entry = '0; era_pc = '0;
      set_wb(0, 0, 0, 0, 6'h0, 9'h0, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      settle();
      chk("reset_rpc", 64'(redirect_pc), 64'(32'h0));
      advance();

      // Directed table: each record is one full commit / redirect / drain sequence.
      for (int k = 0; k < 3; k++) begin
         redirect_ready = 1'b1;
         ex_entry = tbl[k].entry; era_pc = tbl[k].era;
         set_wb(1, tbl[k].hi, tbl[k].ex, tbl[k].er, tbl[k].ec, tbl[k].es, tbl[k].pc);
         settle(); chk("tbl_kill", 64'(wb_kill), 64'(1'b1)); advance();
         set_wb(0, 0, 0, 0, 6'h0, 9'h0, 32'h0);
         settle(); chk("tbl_bus", 64'(csr_in_bus), 64'(tbl[k].exp_bus)); advance();
         ex_entry = 32'hDEAD0000; era_pc = 32'hBEEF0000;
         settle();
         chk("tbl_rpc", 64'(redirect_pc), 64'(tbl[k].exp_rpc));
         chk("tbl_rvalid", 64'(redirect_valid), 64'(1'b1));
         advance();
         for (int j = 0; j < D; j++) begin settle(); advance(); end
         settle();
         chk("tbl_ready", 64'(wb_ready), 64'(1'b1));
         chk("tbl_cnt", 64'(trap_cnt), 64'(tbl[k].exp_cnt));
         advance();
      end

      // Redirect stall with WB noise, then reset while the redirect is pending.
      redirect_ready = 1'b0; ex_entry = 32'h1C00C000;
      set_wb(1, 0, 1, 0, 6'h05, 9'h001, 32'h1C000400);
      settle(); advance();
      set_wb(0, 0, 0, 0, 6'h0, 9'h0, 32'h0);
      settle(); advance();
      for (int j = 0; j < 5; j++) begin
         ex_entry = $urandom;
         set_wb(1, 1'($urandom), 1, 0, 6'h0E, 9'h0, $urandom);
         settle();
         chk("stall_rpc", 64'(redirect_pc), 64'(32'h1C00C000));
         chk("stall_flush", 64'(flush), 64'(1'b1));
         chk("stall_kill", 64'(wb_kill), 64'(1'b0));
         advance();
      end
      set_wb(0, 0, 0, 0, 6'h0, 9'h0, 32'h0);
      settle();
      reset = 1'b1;
      #1;
      chk("arst_flush", 64'(flush), 64'(1'b0));
      chk("arst_rvalid", 64'(redirect_valid), 64'(1'b0));
      chk("arst_bus", 64'(csr_in_bus), 64'(49'h0));
      chk("arst_ready", 64'(wb_ready), 64'(1'b1));
      chk("arst_cnt", 64'(trap_cnt), 64'(16'h0));
      m_busy = 0; m_hs = 0; m_cnt = 0;
      @(negedge clk);
      reset = 1'b0;
      settle(); chk("post_rst_ready", 64'(wb_ready), 64'(1'b1)); advance();

      // Back-to-back exceptions, each retriggering in the first IDLE cycle.
      redirect_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ex_entry = 32'h1C008000 + 32'(k);
         set_wb(1, 0, 1, 0, 6'h0B, 9'h0, 32'h1C001000 + 32'(k * 4));
         settle(); chk("b2b_kill", 64'(wb_kill), 64'(1'b1)); advance();
         set_wb(0, 0, 0, 0, 6'h0, 9'h0, 32'h0);
         for (int j = 0; j < 3 + D - 1; j++) begin settle(); advance(); end
      end
      settle();
      chk("sat_small", 64'(trap_cnt_s), 64'(2'd3));
      chk("sat_wide", 64'(trap_cnt), 64'(16'd5));
      advance();

      // Random traffic against the timeline model.
      for (int n = 0; n < 3000; n++) begin
         set_wb(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                6'($urandom), 9'($urandom), $urandom);
         ex_entry = $urandom; era_pc = $urandom;
         redirect_ready = ($urandom_range(0, 2) != 0);
         settle();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
